// File: rtl/load_store_unit.sv
// Memory-access stage: turns datapath load/store requests into ready/ack bus transfers.
// Latency: stall from request to ack + 1 cycle (IDLE, BUS..., DONE); aborts after TIMEOUT BUS cycles.
// Backpressure: holds the core with stall while waiting for bus_ack; no buffering of new requests.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        access_err,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] load_data_q, load_data_d;
    logic        access_err_q, access_err_d;
    logic        timeout_q, timeout_d;

    logic        acc_vld, is_load, legal, aligned, start;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rdata_ext;

    // Request decode: a simultaneous read and write is treated as a load.
    always_comb begin
        acc_vld = mem_read | mem_write;
        is_load = mem_read;
        if (is_load) begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        start = acc_vld & legal & aligned;

        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Load lane extraction uses the offset and width captured at request time.
    always_comb begin
        case (off_q)
            2'b00:   rbyte = bus_rdata[7:0];
            2'b01:   rbyte = bus_rdata[15:8];
            2'b10:   rbyte = bus_rdata[23:16];
            default: rbyte = bus_rdata[31:24];
        endcase
        rhalf = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  rdata_ext = {{24{rbyte[7]}}, rbyte};
            3'b001:  rdata_ext = {{16{rhalf[15]}}, rhalf};
            3'b100:  rdata_ext = {24'd0, rbyte};
            3'b101:  rdata_ext = {16'd0, rhalf};
            default: rdata_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        off_d        = off_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        load_data_d  = load_data_q;
        access_err_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (start) begin
                    state_d     = BUS;
                    f3_d        = funct3;
                    off_d       = addr[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~is_load;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = is_load ? 4'b0000 : be_new;
                    bus_wdata_d = is_load ? 32'd0 : wdata_new;
                end else if (acc_vld) begin
                    access_err_d = 1'b1;
                end
            end
            BUS: begin
                cnt_d = cnt_q + 16'd1;
                // Ack takes priority over an expiring timeout in the same cycle.
                if (bus_ack || cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'd0;
                    bus_wdata_d = 32'd0;
                    bus_be_d    = 4'b0000;
                    if (bus_ack) begin
                        if (!bus_we_q) load_data_d = rdata_ext;
                    end else begin
                        timeout_d = 1'b1;
                        if (!bus_we_q) load_data_d = 32'd0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            bus_be_q     <= 4'b0000;
            load_data_q  <= 32'd0;
            access_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            load_data_q  <= load_data_d;
            access_err_q <= access_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign stall      = ((state_q == IDLE) && start) || (state_q == BUS);
    assign load_data  = load_data_q;
    assign access_err = access_err_q;
    assign timeout    = timeout_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;

endmodule
